// File: rtl/user_ram_pkg.sv
// Shared types and constants for the user RAM bank.
package user_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam logic [31:0] IDLE_PATTERN_DEF = 32'h16110400;

endpackage

// File: rtl/user_ram_bank_if.sv
// Request/response bus of the user RAM bank; the bank is the slave side.
interface user_ram_bank_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_BIT = 8
);
  logic                  clr_i;
  logic                  req_i;
  logic                  we_i;
  logic [DATA_W/8-1:0]   be_i;
  logic [ADDR_BIT-1:0]   addr_i;
  logic [DATA_W-1:0]     di_i;
  logic                  ready_o;
  logic                  rvalid_o;
  logic [DATA_W-1:0]     do_o;
  logic                  perr_o;

  modport master (
    output clr_i, req_i, we_i, be_i, addr_i, di_i,
    input  ready_o, rvalid_o, do_o, perr_o
  );

  modport slave (
    input  clr_i, req_i, we_i, be_i, addr_i, di_i,
    output ready_o, rvalid_o, do_o, perr_o
  );
endinterface

// File: rtl/user_ram_array.sv
// Single-port synchronous RAM, per-byte write enable, registered read.
// USER_RAM_PARITY_EN adds one even-parity bit per byte and a read-side mismatch flag.
module user_ram_array #(
  parameter int DATA_W   = 32,
  parameter int ADDR_BIT = 8
) (
  input  logic                clk_i,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_BIT-1:0] addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                par_err
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_BIT;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < NB; b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

`ifdef USER_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] rpar;

  // Stored bit equals the XOR of the byte, so byte plus bit has even weight.
  always_ff @(posedge clk_i) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < NB; b++) begin
          if (be[b]) par_mem[addr][b] <= ^wdata[b*8 +: 8];
        end
      end else begin
        rpar <= par_mem[addr];
      end
    end
  end

  always_comb begin
    par_err = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if ((^rdata[b*8 +: 8]) != rpar[b]) par_err = 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: rtl/user_ram_bank.sv
// User RAM bank: clear sweep FSM, request acceptance and read output muxing.
// Optional per-byte parity is enabled by defining USER_RAM_PARITY_EN.
module user_ram_bank
  import user_ram_pkg::*;
#(
  parameter int          DATA_W       = 32,
  parameter int          ADDR_BIT     = 8,
  parameter logic [31:0] IDLE_PATTERN = IDLE_PATTERN_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  user_ram_bank_if.slave   bus
);
  // state    | meaning
  // ST_CLEAR | zeroing one word per cycle at clr_cnt, requests refused
  // ST_READY | serving read/write requests

  localparam int                 NB     = DATA_W / 8;
  localparam logic [DATA_W-1:0]  IDLE_W = DATA_W'(IDLE_PATTERN);

  state_e              state, state_nxt;
  logic [ADDR_BIT-1:0] clr_cnt;
  logic                clearing;
  logic                ready;
  logic                accept;
  logic                rvalid;

  logic                ram_en;
  logic                ram_we;
  logic [NB-1:0]       ram_be;
  logic [ADDR_BIT-1:0] ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;
  logic                ram_par_err;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (&clr_cnt)  state_nxt = ST_READY;
      ST_READY: if (bus.clr_i) state_nxt = ST_CLEAR;
      default:                 state_nxt = ST_CLEAR;
    endcase
  end

  always_comb begin
    clearing = (state == ST_CLEAR);
    ready    = (state == ST_READY) && !bus.clr_i;
  end

  // Wraps to zero on the last sweep write, so READY always holds it at 0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)          clr_cnt <= '0;
    else if (clearing)   clr_cnt <= clr_cnt + 1'b1;
    else if (bus.clr_i)  clr_cnt <= '0;
  end

  assign accept = bus.req_i && ready;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rvalid <= 1'b0;
    else        rvalid <= accept && !bus.we_i;
  end

  assign ram_en    = clearing || accept;
  assign ram_we    = clearing || bus.we_i;
  assign ram_be    = clearing ? '1      : bus.be_i;
  assign ram_addr  = clearing ? clr_cnt : bus.addr_i;
  assign ram_wdata = clearing ? '0      : bus.di_i;

  user_ram_array #(
    .DATA_W   (DATA_W),
    .ADDR_BIT (ADDR_BIT)
  ) u_array (
    .clk_i   (clk_i),
    .en      (ram_en),
    .we      (ram_we),
    .be      (ram_be),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata),
    .par_err (ram_par_err)
  );

  assign bus.ready_o  = ready;
  assign bus.rvalid_o = rvalid;
  assign bus.do_o     = rvalid ? ram_rdata : IDLE_W;
  assign bus.perr_o   = rvalid && ram_par_err;

endmodule
